// File: rtl/regfile_banked.sv
// Banked integer register file: one 32-entry bank per hardware thread, 2 combinational reads, 1 synchronous write.
// After reset, a sweep zeroes every entry while o_busy is high. Optional same-cycle write forwarding: REGFILE_BYPASS_EN.
module regfile_banked #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_THREADS = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [$clog2(NUM_THREADS)-1:0]  i_tid_r,
    input  logic [4:0]                      i_a1,
    input  logic [4:0]                      i_a2,
    output logic [DATA_WIDTH-1:0]           o_rd1,
    output logic [DATA_WIDTH-1:0]           o_rd2,
    input  logic                            i_we3,
    input  logic [$clog2(NUM_THREADS)-1:0]  i_tid_w,
    input  logic [4:0]                      i_a3,
    input  logic [DATA_WIDTH-1:0]           i_wd3,
    output logic                            o_busy
);
    localparam int BITS_THREADS = $clog2(NUM_THREADS);
    localparam int AW           = BITS_THREADS + 5;
    localparam int DEPTH        = NUM_THREADS * 32;

    typedef enum logic {INIT, RUN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AW-1:0]          r_ptr;
    logic [AW-1:0]          w_ptr_nxt;
    logic                   w_mem_we;
    logic [AW-1:0]          w_mem_addr;
    logic [DATA_WIDTH-1:0]  w_mem_wd;
    logic                   w_init;
    logic                   w_fwd1;
    logic                   w_fwd2;

    // Storage carries no reset so it maps onto distributed RAM; the sweep clears it instead.
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_ptr;
        w_mem_wd    = '0;
        case (r_state)
            INIT: begin
                // Sweep owns the single write port; write-back requests are dropped.
                w_mem_we = 1'b1;
                if (r_ptr == AW'(DEPTH - 1)) begin
                    w_state_nxt = RUN;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            RUN: begin
                if (i_we3 && (i_a3 != 5'd0)) begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = {i_tid_w, i_a3};
                    w_mem_wd   = i_wd3;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wd;
        end
    end

    assign w_init = (r_state == INIT);
    assign o_busy = w_init;

`ifdef REGFILE_BYPASS_EN
    assign w_fwd1 = i_we3 && (i_a3 != 5'd0) && (i_tid_w == i_tid_r) && (i_a3 == i_a1);
    assign w_fwd2 = i_we3 && (i_a3 != 5'd0) && (i_tid_w == i_tid_r) && (i_a3 == i_a2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (!w_init && (i_a1 != 5'd0)) begin
            o_rd1 = w_fwd1 ? i_wd3 : r_mem[{i_tid_r, i_a1}];
        end
        if (!w_init && (i_a2 != 5'd0)) begin
            o_rd2 = w_fwd2 ? i_wd3 : r_mem[{i_tid_r, i_a2}];
        end
    end
endmodule

// File: tb/tb_regfile_banked.sv
// Bench for regfile_banked: reset sweep, vector table through an expected-value queue, INIT and mid-run reset cases.
module tb_regfile_banked;
    localparam int DW = 32;
    localparam int NT = 8;
    localparam int TB = $clog2(NT);
    localparam int SWEEP = NT * 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [TB-1:0] tid_r = '0;
    logic [4:0]    a1 = '0;
    logic [4:0]    a2 = '0;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          we3 = 1'b0;
    logic [TB-1:0] tid_w = '0;
    logic [4:0]    a3 = '0;
    logic [DW-1:0] wd3 = '0;
    logic          busy;

    regfile_banked #(.DATA_WIDTH(DW), .NUM_THREADS(NT)) dut (
        .i_clk(clk), .i_rst(rst), .i_tid_r(tid_r), .i_a1(a1), .i_a2(a2),
        .o_rd1(rd1), .o_rd2(rd2), .i_we3(we3), .i_tid_w(tid_w), .i_a3(a3),
        .i_wd3(wd3), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [TB-1:0] tw;
        logic [4:0]    wa;
        logic [DW-1:0] wd;
        logic [TB-1:0] tr;
        logic [4:0]    ra1;
        logic [4:0]    ra2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    typedef struct {
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Counts edges from reset release until busy falls; optionally injects a write at sweep cycle 10.
    task automatic sweep_and_count(input string name, input bit inject);
        int cyc;
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject && cyc == 10) begin
                we3 = 1'b1; tid_w = 3'd1; a3 = 5'd7; wd3 = 32'h1234;
            end else begin
                we3 = 1'b0;
            end
            if (!busy) break;
        end
        check(name, 32'(cyc), 32'(SWEEP));
    endtask

    function automatic vec_t mk(input logic we, input int tw, input int wa, input logic [DW-1:0] wd,
                                input int tr, input int ra1, input int ra2,
                                input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        vec_t v;
        v.we = we; v.tw = TB'(tw); v.wa = 5'(wa); v.wd = wd;
        v.tr = TB'(tr); v.ra1 = 5'(ra1); v.ra2 = 5'(ra2); v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    initial begin
        int bad;
        exp_t e;

        vecs[0]  = mk(1, 3, 5,  32'hDEADBEEF, 3, 6,  0,  32'h0, 32'h0);
        vecs[1]  = mk(0, 0, 0,  32'h0,        3, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[2]  = mk(0, 0, 0,  32'h0,        2, 5,  5,  32'h0, 32'h0);
        vecs[3]  = mk(1, 0, 0,  32'hFFFFFFFF, 0, 0,  0,  32'h0, 32'h0);
        vecs[4]  = mk(0, 0, 0,  32'h0,        0, 0,  0,  32'h0, 32'h0);
        vecs[5]  = mk(1, 2, 5,  32'h11111111, 3, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[6]  = mk(0, 0, 0,  32'h0,        2, 5,  0,  32'h11111111, 32'h0);
        vecs[7]  = mk(1, 4, 9,  32'hA5A5A5A5, 4, 8,  9,  32'h0, BYP ? 32'hA5A5A5A5 : 32'h0);
        vecs[8]  = mk(0, 0, 0,  32'h0,        4, 9,  9,  32'hA5A5A5A5, 32'hA5A5A5A5);
        vecs[9]  = mk(1, 4, 9,  32'h12345678, 4, 9,  3,  BYP ? 32'h12345678 : 32'hA5A5A5A5, 32'h0);
        vecs[10] = mk(0, 5, 1,  32'hCAFEF00D, 5, 1,  1,  32'h0, 32'h0);
        vecs[11] = mk(0, 0, 0,  32'h0,        5, 1,  1,  32'h0, 32'h0);
        vecs[12] = mk(1, 7, 31, 32'h55,       6, 31, 31, 32'h0, 32'h0);
        vecs[13] = mk(1, 3, 21, 32'h0BADCAFE, 7, 31, 5,  32'h55, 32'h0);
        vecs[14] = mk(0, 0, 0,  32'h0,        3, 20, 5,  32'h0, 32'hDEADBEEF);
        vecs[15] = mk(0, 0, 0,  32'h0,        3, 21, 9,  32'h0BADCAFE, 32'h0);

        // Reset state
        #1 rst = 1'b1;
        tid_r = 3'd0; a1 = 5'd3; a2 = 5'd4;
        @(posedge clk); @(posedge clk); #1;
        check("busy_in_reset", 32'(busy), 32'd1);
        check("rd1_in_reset", rd1, 32'h0);
        check("rd2_in_reset", rd2, 32'h0);
        rst = 1'b0;

        sweep_and_count("sweep_len", 1'b1);
        we3 = 1'b0;

        bad = 0;
        for (int t = 0; t < NT; t++) begin
            for (int a = 0; a < 32; a++) begin
                tid_r = TB'(t); a1 = 5'(a); a2 = 5'(31 - a);
                #1;
                if (rd1 !== 32'h0 || rd2 !== 32'h0) bad++;
            end
        end
        check("all_zero_after_sweep", 32'(bad), 32'd0);

        tid_r = 3'd1; a1 = 5'd7; a2 = 5'd7;
        #1;
        check("init_write_dropped", rd1, 32'h0);

        // Vector table through the expected-value queue
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            we3 = vecs[i].we; tid_w = vecs[i].tw; a3 = vecs[i].wa; wd3 = vecs[i].wd;
            tid_r = vecs[i].tr; a1 = vecs[i].ra1; a2 = vecs[i].ra2;
            e.e1 = vecs[i].e1; e.e2 = vecs[i].e2;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("vec%0d_rd1", i), rd1, e.e1);
            check($sformatf("vec%0d_rd2", i), rd2, e.e2);
        end
        @(posedge clk); #1;
        we3 = 1'b0;

        bad = 0;
        for (int t = 0; t < NT; t++) begin
            tid_r = TB'(t); a1 = 5'd0; a2 = 5'd0;
            #1;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) bad++;
        end
        check("x0_all_threads", 32'(bad), 32'd0);

        // Mid-run reset: tid 7 x31 holds 0x55 and is the last entry swept
        tid_r = 3'd7; a1 = 5'd31; a2 = 5'd31;
        #1;
        check("pre_reset_t7x31", rd1, 32'h55);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("busy_async_reset", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rd_gated_in_init", rd1, 32'h0);
        sweep_and_count("sweep_len_midrun", 1'b0);
        tid_r = 3'd7; a1 = 5'd31; a2 = 5'd31;
        #1;
        check("t7x31_cleared_rd1", rd1, 32'h0);
        check("t7x31_cleared_rd2", rd2, 32'h0);
        tid_r = 3'd3; a1 = 5'd5;
        #1;
        check("t3x5_cleared", rd1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
